// File: rtl/cla_sub64_pipe_pkg.sv
// Shared definitions for the pipelined 64-bit carry-lookahead subtractor.
//   WIDTH      - operand / result width
//   SLICE_W    - bits resolved per pipeline stage
//   NUM_STAGES - number of pipeline stages (WIDTH / SLICE_W)
//   stage_t    - contents of one pipeline stage register
//   STAGE_RST  - reset value of a stage register
package cla_sub64_pipe_pkg;

    localparam int WIDTH      = 64;
    localparam int SLICE_W    = 16;
    localparam int NUM_STAGES = 4;

    typedef struct packed {
        logic             valid;
        logic             carry;     // carry out of the slice just computed
        logic             zero_acc;  // all diff slices computed so far are zero
        logic [WIDTH-1:0] diff;      // diff bits produced so far
        logic [WIDTH-1:0] op1_rem;   // minuend, still needed by later slices
        logic [WIDTH-1:0] op2_rem;   // subtrahend, still needed by later slices
    } stage_t;

    // Carry resets to 1 so that the exported borrow (inverted carry)
    // comes out of reset as 0.
    localparam stage_t STAGE_RST = '{
        valid:    1'b0,
        carry:    1'b1,
        zero_acc: 1'b0,
        diff:     '0,
        op1_rem:  '0,
        op2_rem:  '0
    };

endpackage

// File: rtl/sub16_cla.sv
// Combinational 16-bit adder slice used for subtraction (a + b_inv + cin).
// Four 4-bit carry-lookahead groups with a second lookahead level across
// the groups.
//   a     - minuend slice
//   b_inv - inverted subtrahend slice
//   cin   - carry in (1 for the lowest slice of a subtraction)
//   s     - sum / difference slice
//   cout  - carry out of bit 15
//   z     - 1 when s is all zeros
module sub16_cla
    import cla_sub64_pipe_pkg::*;
(
    input  logic [SLICE_W-1:0] a,
    input  logic [SLICE_W-1:0] b_inv,
    input  logic               cin,
    output logic [SLICE_W-1:0] s,
    output logic               cout,
    output logic               z
);

    logic [SLICE_W-1:0] p;
    logic [SLICE_W-1:0] g;
    logic [SLICE_W-1:0] c;      // carry into each bit
    logic [3:0]         grp_p;
    logic [3:0]         grp_g;
    logic [4:0]         grp_c;  // carry into each 4-bit group, [4] = cout

    assign p = a ^ b_inv;
    assign g = a & b_inv;

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_grp
            localparam int B = 4 * gi;
            assign c[B]   = grp_c[gi];
            assign c[B+1] = g[B] | (p[B] & grp_c[gi]);
            assign c[B+2] = g[B+1] | (p[B+1] & g[B]) | (p[B+1] & p[B] & grp_c[gi]);
            assign c[B+3] = g[B+2] | (p[B+2] & g[B+1]) | (p[B+2] & p[B+1] & g[B])
                          | (p[B+2] & p[B+1] & p[B] & grp_c[gi]);
            assign grp_p[gi] = &p[B+3:B];
            assign grp_g[gi] = g[B+3] | (p[B+3] & g[B+2]) | (p[B+3] & p[B+2] & g[B+1])
                             | (p[B+3] & p[B+2] & p[B+1] & g[B]);
        end
    endgenerate

    // Second-level lookahead: group carries straight from cin, no ripple.
    assign grp_c[0] = cin;
    assign grp_c[1] = grp_g[0] | (grp_p[0] & cin);
    assign grp_c[2] = grp_g[1] | (grp_p[1] & grp_g[0]) | (grp_p[1] & grp_p[0] & cin);
    assign grp_c[3] = grp_g[2] | (grp_p[2] & grp_g[1]) | (grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[2] & grp_p[1] & grp_p[0] & cin);
    assign grp_c[4] = grp_g[3] | (grp_p[3] & grp_g[2]) | (grp_p[3] & grp_p[2] & grp_g[1])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_g[0])
                    | (grp_p[3] & grp_p[2] & grp_p[1] & grp_p[0] & cin);

    assign s    = p ^ c;
    assign cout = grp_c[4];
    assign z    = ~|s;

endmodule

// File: rtl/cla_sub64_pipe.sv
// Four-stage pipelined 64-bit subtractor, diff = op1 - op2 (mod 2^64).
// Stage k resolves bits [16k+15:16k]; the carry between slices travels in
// the stage registers. Global stall, per-stage valid bits, synchronous flush.
//   clock, reset        - rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready - input handshake for op1 / op2
//   op1, op2            - minuend, subtrahend
//   flush               - drop everything in flight at the next edge
//   out_valid/out_ready - output handshake for diff / borrow / zero
//   diff, borrow, zero  - result, op2 > op1 (unsigned), diff == 0
module cla_sub64_pipe
    import cla_sub64_pipe_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             flush,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] diff,
    output logic             borrow,
    output logic             zero
);

    stage_t stage_q [NUM_STAGES];
    stage_t stage_d [NUM_STAGES];

    logic               stall;
    logic               in_fire;
    logic [SLICE_W-1:0] slice_a     [NUM_STAGES];
    logic [SLICE_W-1:0] slice_b_inv [NUM_STAGES];
    logic               slice_cin   [NUM_STAGES];
    logic [SLICE_W-1:0] slice_s     [NUM_STAGES];
    logic               slice_cout  [NUM_STAGES];
    logic               slice_z     [NUM_STAGES];

    assign stall    = stage_q[NUM_STAGES-1].valid && !out_ready;
    assign in_ready = !stall;
    assign in_fire  = in_valid && in_ready;

    // Slice 0 works straight off the inputs; later slices off the
    // previous stage register. The +1 of two's complement enters as cin.
    always_comb begin
        slice_a[0]     = op1[SLICE_W-1:0];
        slice_b_inv[0] = ~op2[SLICE_W-1:0];
        slice_cin[0]   = 1'b1;
        for (int k = 1; k < NUM_STAGES; k++) begin
            slice_a[k]     = stage_q[k-1].op1_rem[k*SLICE_W +: SLICE_W];
            slice_b_inv[k] = ~stage_q[k-1].op2_rem[k*SLICE_W +: SLICE_W];
            slice_cin[k]   = stage_q[k-1].carry;
        end
    end

    generate
        for (genvar gi = 0; gi < NUM_STAGES; gi++) begin : g_slice
            sub16_cla u_slice (
                .a     (slice_a[gi]),
                .b_inv (slice_b_inv[gi]),
                .cin   (slice_cin[gi]),
                .s     (slice_s[gi]),
                .cout  (slice_cout[gi]),
                .z     (slice_z[gi])
            );
        end
    endgenerate

    always_comb begin
        stage_d = stage_q;
        if (flush) begin
            // Valid bits only; data is left as it was.
            for (int k = 0; k < NUM_STAGES; k++) begin
                stage_d[k].valid = 1'b0;
            end
        end else if (!stall) begin
            stage_d[0].valid    = in_fire;
            stage_d[0].carry    = slice_cout[0];
            stage_d[0].zero_acc = slice_z[0];
            stage_d[0].diff     = {{(WIDTH-SLICE_W){1'b0}}, slice_s[0]};
            stage_d[0].op1_rem  = op1;
            stage_d[0].op2_rem  = op2;
            for (int k = 1; k < NUM_STAGES; k++) begin
                stage_d[k]                            = stage_q[k-1];
                stage_d[k].carry                      = slice_cout[k];
                stage_d[k].zero_acc                   = stage_q[k-1].zero_acc & slice_z[k];
                stage_d[k].diff[k*SLICE_W +: SLICE_W] = slice_s[k];
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stage_q[k] <= STAGE_RST;
            end
        end else begin
            for (int k = 0; k < NUM_STAGES; k++) begin
                stage_q[k] <= stage_d[k];
            end
        end
    end

    assign out_valid = stage_q[NUM_STAGES-1].valid;
    assign diff      = stage_q[NUM_STAGES-1].diff;
    assign borrow    = ~stage_q[NUM_STAGES-1].carry;
    assign zero      = stage_q[NUM_STAGES-1].zero_acc;

endmodule

// File: tb/tb_cla_sub64_pipe.sv
// Self-checking bench for cla_sub64_pipe: directed vectors, a stalled
// stream, reset mid-operation, and a randomised run with flush pulses.
module tb_cla_sub64_pipe;

    logic        clock = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] op1;
    logic [63:0] op2;
    logic        flush;
    logic        out_valid;
    logic        out_ready;
    logic [63:0] diff;
    logic        borrow;
    logic        zero;

    cla_sub64_pipe dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .op1       (op1),
        .op2       (op2),
        .flush     (flush),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .diff      (diff),
        .borrow    (borrow),
        .zero      (zero)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [63:0] d;
        logic        b;
        logic        z;
    } exp_t;

    exp_t exp_q[$];
    int   n_cmp = 0;
    int   n_bad = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Output monitor: checks every consumed result against the scoreboard
    // and checks that outputs hold while stalled.
    logic        stall_prev = 1'b0;
    logic [63:0] prev_d;
    logic        prev_b;
    logic        prev_z;

    always @(negedge clock) begin
        if (reset) begin
            stall_prev = 1'b0;
        end else begin
            if (stall_prev) begin
                check_val("stall_valid", {63'b0, out_valid}, 64'd1);
                check_val("stall_diff", diff, prev_d);
                check_val("stall_borrow", {63'b0, borrow}, {63'b0, prev_b});
                check_val("stall_zero", {63'b0, zero}, {63'b0, prev_z});
            end
            if (out_valid && out_ready) begin
                if (exp_q.size() == 0) begin
                    check_val("spurious_out", {63'b0, out_valid}, 64'd0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check_val("diff", diff, e.d);
                    check_val("borrow", {63'b0, borrow}, {63'b0, e.b});
                    check_val("zero", {63'b0, zero}, {63'b0, e.z});
                end
            end
            stall_prev = out_valid && !out_ready && !flush;
            prev_d     = diff;
            prev_b     = borrow;
            prev_z     = zero;
        end
    end

    // One clock cycle of stimulus; called and returning at posedge+1.
    task automatic step(input logic v, input logic [63:0] a, input logic [63:0] b,
                        input logic [63:0] ed, input logic eb, input logic ez,
                        input logic ordy, input logic fl, output logic acc);
        in_valid  = v;
        op1       = a;
        op2       = b;
        out_ready = ordy;
        flush     = fl;
        @(negedge clock);
        acc = in_valid && in_ready && !flush;
        if (acc) exp_q.push_back('{ed, eb, ez});
        @(posedge clock);
        #1;
        if (fl) exp_q.delete();
        in_valid = 1'b0;
        flush    = 1'b0;
    endtask

    task automatic idle(input logic ordy);
        logic acc;
        step(1'b0, 64'd0, 64'd0, 64'd0, 1'b0, 1'b0, ordy, 1'b0, acc);
    endtask

    task automatic drain();
        for (int i = 0; i < 20 && exp_q.size() != 0; i++) idle(1'b1);
        check_val("drain_left", 64'(exp_q.size()), 64'd0);
    endtask

    logic [64:0] ref_w;
    logic        acc;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        op1       = '0;
        op2       = '0;
        flush     = 1'b0;
        out_ready = 1'b1;

        // Reset state
        #3;
        check_val("rst_out_valid", {63'b0, out_valid}, 64'd0);
        check_val("rst_in_ready", {63'b0, in_ready}, 64'd1);
        check_val("rst_diff", diff, 64'd0);
        check_val("rst_borrow", {63'b0, borrow}, 64'd0);
        check_val("rst_zero", {63'b0, zero}, 64'd0);
        repeat (2) @(posedge clock);
        #1;
        reset = 1'b0;

        // 5 - 3 accepted on the first edge after reset; 4-cycle latency
        step(1'b1, 64'd5, 64'd3, 64'd2, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        check_val("first_accept", {63'b0, acc}, 64'd1);
        check_val("lat_c1", {63'b0, out_valid}, 64'd0);
        idle(1'b1);
        check_val("lat_c2", {63'b0, out_valid}, 64'd0);
        idle(1'b1);
        check_val("lat_c3", {63'b0, out_valid}, 64'd0);
        idle(1'b1);
        check_val("lat_c4", {63'b0, out_valid}, 64'd1);
        check_val("lat_diff", diff, 64'd2);
        idle(1'b1);

        // Directed vectors back to back
        step(1'b1, 64'd0, 64'd1, 64'hFFFF_FFFF_FFFF_FFFF, 1'b1, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 64'h0000_0001_0000_0000, 64'd1, 64'h0000_0000_FFFF_FFFF, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 64'h1234_5678_9ABC_DEF0, 64'h1234_5678_9ABC_DEF0, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        step(1'b1, 64'h8000_0000_0000_0000, 64'h0000_0000_0001_0000, 64'h7FFF_FFFF_FFFF_0000, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 64'h0000_0000_0000_0003, 64'h0001_0000_0000_0000, 64'hFFFF_0000_0000_0003, 1'b1, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 64'h0001_0000_0000_0005, 64'h0000_0000_0000_0005, 64'h0001_0000_0000_0000, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 64'hFFFF_FFFF_FFFF_FFFF, 64'hFFFF_FFFF_FFFF_FFFF, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        drain();

        // Stream of 8 with out_ready pattern 1,0,0,1
        begin
            int i;
            i = 0;
            for (int c = 0; c < 100 && i < 8; c++) begin
                step(1'b1, 64'd1000, 64'(i), 64'(1000 - i), 1'b0, 1'b0,
                     (c % 4 == 0) || (c % 4 == 3), 1'b0, acc);
                if (acc) i++;
            end
            check_val("stream_accepted", 64'(i), 64'd8);
        end
        drain();

        // Reset with three operations in flight
        step(1'b1, 64'd9, 64'd1, 64'd8, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 64'd9, 64'd2, 64'd7, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 64'd9, 64'd3, 64'd6, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        #2;
        reset = 1'b1;
        #1;
        check_val("midrst_out_valid", {63'b0, out_valid}, 64'd0);
        check_val("midrst_in_ready", {63'b0, in_ready}, 64'd1);
        check_val("midrst_diff", diff, 64'd0);
        exp_q.delete();
        @(posedge clock);
        @(posedge clock);
        #1;
        reset = 1'b0;
        for (int i = 0; i < 6; i++) idle(1'b1);  // monitor flags any stale result
        step(1'b1, 64'h10, 64'h10, 64'd0, 1'b0, 1'b1, 1'b1, 1'b0, acc);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);
        check_val("post_rst_valid", {63'b0, out_valid}, 64'd1);
        check_val("post_rst_zero", {63'b0, zero}, 64'd1);
        drain();

        // Flush: drops in-flight work and the simultaneous input
        step(1'b1, 64'd50, 64'd1, 64'd49, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 64'd50, 64'd2, 64'd48, 1'b0, 1'b0, 1'b1, 1'b0, acc);
        step(1'b1, 64'd50, 64'd3, 64'd47, 1'b0, 1'b0, 1'b1, 1'b1, acc);
        for (int i = 0; i < 6; i++) begin
            idle(1'b1);
            check_val("flush_no_out", {63'b0, out_valid}, 64'd0);
        end

        // Randomised run with reference subtraction and flush pulses
        for (int i = 0; i < 10000; i++) begin
            logic [63:0] a;
            logic [63:0] b;
            a = {$urandom, $urandom};
            b = {$urandom, $urandom};
            if ($urandom_range(0, 15) == 0) b = a;
            if ($urandom_range(0, 15) == 0) a = 64'($urandom_range(0, 3));
            ref_w = {1'b0, a} - {1'b0, b};
            step($urandom_range(0, 3) != 0, a, b, ref_w[63:0], ref_w[64], ref_w[63:0] == 64'd0,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 63) == 0, acc);
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
